conv_16_sdiv_24s_8s: RTL and testbench
======================================

# conv_16_sdiv_24s_8s

Sequential signed divider that reverses the convolution datapath's 16×8 → 24-bit signed multiply. It takes a 24-bit signed dividend (product or accumulator) and an 8-bit signed divisor (weight or scale) and returns a saturated 16-bit signed quotient and an 8-bit remainder. It sits after the accumulator in the requantize/normalize path. The core is radix-2 restoring division, one quotient bit per enabled cycle, with a start/done handshake.

## Interface
Parameters:
- din0_WIDTH, 24, dividend width (signed)
- din1_WIDTH, 8, divisor width (signed); also the remainder width
- dout_WIDTH, 16, quotient width (signed, saturated)

Ports:
- ap_clk  in  1  single clock, rising edge
- ap_rst_n  in  1  synchronous, active-low reset
- ce  in  1  clock enable; when low, all state and outputs hold
- start  in  1  request; sampled only in IDLE with ce=1
- din0  in  din0_WIDTH  dividend, captured on the accepted start edge
- din1  in  din1_WIDTH  divisor, captured on the accepted start edge
- busy  out  1  high in CALC and FIX
- done  out  1  one-enabled-cycle pulse when results update
- dout  out  dout_WIDTH  quotient, held until the next done
- rem  out  din1_WIDTH  remainder, held until the next done
- ovf  out  1  quotient saturated (valid with done, held)
- div0  out  1  divisor was zero (valid with done, held)

## Operation
- States: IDLE → CALC → FIX → IDLE. FSM advances only when ce=1.
- IDLE: on start=1, register |din0| (din0_WIDTH bits unsigned; |−2^23|=2^23 fits), |din1|, both signs, and zero flag; load counter=din0_WIDTH; go to CALC. While not in IDLE, start is ignored (no queuing).
- CALC: shift partial remainder left by one, bringing in the next dividend bit MSB-first. Subtract |divisor|; if non-negative, keep the result and set the quotient bit to 1. Decrement counter; go to FIX after din0_WIDTH iterations.
- FIX, truncating (C) semantics:
  - quotient sign = sign(din0) XOR sign(din1)
  - remainder sign = sign(din0)
  - if the signed quotient lies outside [−2^(dout_WIDTH−1), 2^(dout_WIDTH−1)−1], clamp to that bound and set ovf=1
  - divisor zero: dout = 32767 if din0≥0 else −32768, rem=0, div0=1, ovf=0
  - register dout/rem/ovf/div0, pulse done, return to IDLE
- Reset (any state, including mid-CALC): state=IDLE; busy, done, dout, rem, ovf, div0 all 0. An in-flight operation is discarded and no done is produced.

## Timing
- Accepted start at enabled edge E0. CALC occupies edges E0+1..E0+din0_WIDTH. FIX at edge E0+din0_WIDTH+1 updates the outputs. done is high for the following cycle.
- Latency is 25 enabled edges at default widths.
- busy is high from after E0 through the FIX edge. done and busy are never high together.
- Back-to-back: start may be high in the done cycle and is accepted, for one result per 26 enabled cycles.
- ce=0 stretches latency cycle-for-cycle. done stays asserted while ce=0 and drops on the first enabled edge.

## Configuration
- CONV_16_SDIV_ROUND_EN defined: FIX rounds half away from zero. If 2·|rem| ≥ |divisor|, the quotient magnitude increments by 1 before saturation; ovf reflects the post-rounding clamp. rem still reports the truncation remainder. Latency is unchanged.
- Undefined: pure truncation toward zero, no rounding logic.

## Test plan
- din0=1000, din1=7 → dout=142, rem=6, ovf=0, div0=0, done exactly 25 edges after start; with ROUND_EN, dout=143.
- din0=−1000, din1=7 → dout=−142, rem=−6; din0=1000, din1=−7 → dout=−142, rem=6.
- Saturation: din0=8388607, din1=1 → dout=32767, ovf=1. din0=−8388608, din1=−1 → dout=32767, ovf=1. din0=−8388608, din1=1 → dout=−32768, ovf=1.
- Divide by zero: din0=−5, din1=0 → dout=−32768, rem=0, div0=1. din0=5, din1=0 → dout=32767, rem=0, div0=1.
- Handshake: start re-asserted during busy is ignored. start in the done cycle is accepted, with the second done 26 edges after the first. ce=0 for 10 cycles mid-CALC → done 35 edges after start.
- Reset: ap_rst_n=0 for one edge at CALC iteration 12 → next cycle busy=0, done=0, dout=0, rem=0, ovf=0, div0=0, and no done follows.

Source files
------------

// File: rtl/conv_16_sdiv_24s_8s.sv
// conv_16_sdiv_24s_8s
// Sequential signed divider for the requantize/normalize path. It divides a
// signed accumulator value (din0) by a signed weight/scale (din1) using radix-2
// restoring division on magnitudes, one quotient bit per enabled cycle. It then
// applies C-style truncating signs and saturates the quotient to dout_WIDTH.
//
// Optional feature: define CONV_16_SDIV_ROUND_EN to round the quotient half
// away from zero before saturation. rem still reports the truncation remainder.
//
// Ports:
//   ap_clk    clock, rising edge
//   ap_rst_n  synchronous active-low reset
//   ce        clock enable; all state and outputs hold while low
//   start     request, sampled in IDLE only
//   din0      signed dividend (din0_WIDTH)
//   din1      signed divisor (din1_WIDTH)
//   busy      high while in CALC or FIX
//   done      one-enabled-cycle pulse when results update
//   dout      saturated signed quotient (dout_WIDTH)
//   rem       signed remainder, sign follows dividend (din1_WIDTH)
//   ovf       quotient was clamped
//   div0      divisor was zero
module conv_16_sdiv_24s_8s #(
    parameter int din0_WIDTH = 24,
    parameter int din1_WIDTH = 8,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div0
);

    localparam int CW = $clog2(din0_WIDTH + 1);

    // Quotient magnitude limits, one bit wider than the dividend so a
    // rounded-up magnitude never wraps before the compare.
    localparam logic [din0_WIDTH:0] POS_LIM = (din0_WIDTH+1)'((1 << (dout_WIDTH-1)) - 1);
    localparam logic [din0_WIDTH:0] NEG_LIM = (din0_WIDTH+1)'(1 << (dout_WIDTH-1));
    localparam logic [dout_WIDTH-1:0] Q_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] Q_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [din0_WIDTH-1:0]  dvd_q, dvd_d;    // dividend bits out MSB-first, quotient bits in LSB
    logic [din1_WIDTH-1:0]  dsr_q, dsr_d;    // |divisor|
    logic [din1_WIDTH-1:0]  racc_q, racc_d;  // partial remainder, always < |divisor|
    logic                   s0_q, s0_d;      // dividend sign
    logic                   s1_q, s1_d;      // divisor sign
    logic                   z_q, z_d;        // divisor is zero
    logic [dout_WIDTH-1:0]  dout_q, dout_d;
    logic [din1_WIDTH-1:0]  rem_q, rem_d;
    logic                   ovf_q, ovf_d;
    logic                   div0_q, div0_d;
    logic                   done_q, done_d;

    logic [din0_WIDTH-1:0]  a_mag;
    logic [din1_WIDTH-1:0]  b_mag;
    logic [din1_WIDTH:0]    shifted;
    logic [din0_WIDTH:0]    qmag;
    logic                   neg;

    always_comb begin
        // |din0| fits unsigned in din0_WIDTH bits, including the most negative value.
        a_mag   = din0[din0_WIDTH-1] ? ({din0_WIDTH{1'b0}} - din0) : din0;
        b_mag   = din1[din1_WIDTH-1] ? ({din1_WIDTH{1'b0}} - din1) : din1;
        shifted = {racc_q, dvd_q[din0_WIDTH-1]};
        neg     = s0_q ^ s1_q;

        qmag = {1'b0, dvd_q};
`ifdef CONV_16_SDIV_ROUND_EN
        // Half away from zero: round up the magnitude when 2*|rem| >= |divisor|.
        if ({racc_q, 1'b0} >= {1'b0, dsr_q})
            qmag = qmag + {{din0_WIDTH{1'b0}}, 1'b1};
`endif

        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        racc_d  = racc_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        z_d     = z_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        div0_d  = div0_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = a_mag;
                    dsr_d   = b_mag;
                    racc_d  = '0;
                    s0_d    = din0[din0_WIDTH-1];
                    s1_d    = din1[din1_WIDTH-1];
                    z_d     = (din1 == '0);
                    cnt_d   = CW'(din0_WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // The difference is below |divisor|, so the low bits are exact.
                if (shifted >= {1'b0, dsr_q}) begin
                    racc_d = shifted[din1_WIDTH-1:0] - dsr_q;
                    dvd_d  = {dvd_q[din0_WIDTH-2:0], 1'b1};
                end else begin
                    racc_d = shifted[din1_WIDTH-1:0];
                    dvd_d  = {dvd_q[din0_WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (z_q) begin
                    dout_d = s0_q ? Q_MIN : Q_MAX;
                    rem_d  = '0;
                    ovf_d  = 1'b0;
                    div0_d = 1'b1;
                end else begin
                    div0_d = 1'b0;
                    rem_d  = s0_q ? ({din1_WIDTH{1'b0}} - racc_q) : racc_q;
                    if (neg) begin
                        ovf_d  = (qmag > NEG_LIM);
                        dout_d = (qmag > NEG_LIM) ? Q_MIN
                                                  : ({dout_WIDTH{1'b0}} - qmag[dout_WIDTH-1:0]);
                    end else begin
                        ovf_d  = (qmag > POS_LIM);
                        dout_d = (qmag > POS_LIM) ? Q_MAX : qmag[dout_WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            racc_q  <= '0;
            s0_q    <= 1'b0;
            s1_q    <= 1'b0;
            z_q     <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            racc_q  <= racc_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            z_q     <= z_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            div0_q  <= div0_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dout = dout_q;
    assign rem  = rem_q;
    assign ovf  = ovf_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_conv_16_sdiv_24s_8s.sv
// Bench for conv_16_sdiv_24s_8s. Expected results come from an integer
// model pushed to a scoreboard queue at start time and popped on done.
module tb_conv_16_sdiv_24s_8s;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [23:0] din0 = '0;
    logic [7:0]  din1 = '0;
    logic        busy, done, ovf, div0;
    logic [15:0] dout;
    logic [7:0]  rem;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] dout;
        logic [7:0]  rem;
        logic        ovf;
        logic        div0;
    } res_t;

    res_t sb[$];

    conv_16_sdiv_24s_8s dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .dout(dout), .rem(rem), .ovf(ovf), .div0(div0)
    );

    always #5 ap_clk = ~ap_clk;

    function automatic res_t model(input int a, input int b);
        res_t r;
        int   q, m;
        bit   neg;
        r.ovf  = 1'b0;
        r.div0 = 1'b0;
        if (b == 0) begin
            r.div0 = 1'b1;
            r.rem  = 8'h00;
            r.dout = (a >= 0) ? 16'h7fff : 16'h8000;
            return r;
        end
        q   = a / b;
        m   = a % b;
        neg = (a < 0) != (b < 0);
`ifdef CONV_16_SDIV_ROUND_EN
        if (2 * (m < 0 ? -m : m) >= (b < 0 ? -b : b))
            q = neg ? q - 1 : q + 1;
`endif
        if (q > 32767) begin
            q = 32767;  r.ovf = 1'b1;
        end else if (q < -32768) begin
            q = -32768; r.ovf = 1'b1;
        end
        r.dout = q[15:0];
        r.rem  = m[7:0];
        return r;
    endfunction

    // Called at a negedge: pushes the expected result, pulses start for one
    // edge, then counts edges after the accept edge until done (lat=-1 on timeout).
    task automatic issue(input int a, input int b, output int lat);
        sb.push_back(model(a, b));
        start = 1'b1;
        din0  = a[23:0];
        din1  = b[7:0];
        @(posedge ap_clk);
        @(negedge ap_clk);
        start = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
            if (done) break;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        ce = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        n_tests++;
        if ({busy, done, dout, rem, ovf, div0} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b dout=%h rem=%h ovf=%b div0=%b want all 0",
                     busy, done, dout, rem, ovf, div0);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_arith();
        int   va[10] = '{1000, -1000, 1000, 8388607, -8388608, -8388608, -5, 5, 12345, -77};
        int   vb[10] = '{7, 7, -7, 1, -1, 1, 0, 0, -128, 10};
        int   lat;
        res_t e;
        for (int i = 0; i < 10; i++) begin
            issue(va[i], vb[i], lat);
            e = sb.pop_front();
            n_tests++;
            if (lat != 25) begin
                n_fail++;
                $display("FAIL arith_latency[%0d]: got %0d want 25", i, lat);
            end
            n_tests++;
            if (dout !== e.dout) begin
                n_fail++;
                $display("FAIL arith_dout[%0d]: got %0d want %0d", i, $signed(dout), $signed(e.dout));
            end
            n_tests++;
            if (rem !== e.rem) begin
                n_fail++;
                $display("FAIL arith_rem[%0d]: got %0d want %0d", i, $signed(rem), $signed(e.rem));
            end
            n_tests++;
            if (ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL arith_ovf[%0d]: got %b want %b", i, ovf, e.ovf);
            end
            n_tests++;
            if (div0 !== e.div0) begin
                n_fail++;
                $display("FAIL arith_div0[%0d]: got %b want %b", i, div0, e.div0);
            end
        end
    endtask

    task automatic test_start_ignored();
        int   lat, extra;
        bit   seen;
        res_t e;
        sb.push_back(model(300, -9));
        start = 1'b1;
        din0 = 24'd300;
        din1 = 8'hF7;
        @(posedge ap_clk);
        @(negedge ap_clk);
        start = 1'b0;
        lat = 0;
        seen = 1'b0;
        while (lat < 200 && !seen) begin
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
            if (lat == 3) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_in_calc: got %b want 1", busy);
                end
            end
            start = (lat >= 5 && lat < 8);
            if (start) begin
                din0 = 24'd77;
                din1 = 8'd2;
            end
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        e = sb.pop_front();
        n_tests++;
        if (lat != 25) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d want 25", lat);
        end
        n_tests++;
        if (dout !== e.dout || rem !== e.rem) begin
            n_fail++;
            $display("FAIL ignore_result: got dout=%0d rem=%0d want dout=%0d rem=%0d",
                     $signed(dout), $signed(rem), $signed(e.dout), $signed(e.rem));
        end
        extra = 0;
        repeat (40) begin
            @(posedge ap_clk);
            @(negedge ap_clk);
            if (done) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL ignore_no_second_done: got %0d dones want 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int   lat1, lat2;
        res_t e;
        issue(1000, 7, lat1);
        e = sb.pop_front();
        n_tests++;
        if (lat1 != 25 || dout !== e.dout) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d dout=%0d want lat=25 dout=%0d",
                     lat1, $signed(dout), $signed(e.dout));
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_with_done: got busy=%b want 0", busy);
        end
        // start raised in the done cycle
        issue(-20000, 3, lat2);
        e = sb.pop_front();
        n_tests++;
        if (lat2 + 1 != 26) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want 26", lat2 + 1);
        end
        n_tests++;
        if (dout !== e.dout || rem !== e.rem) begin
            n_fail++;
            $display("FAIL b2b_second: got dout=%0d rem=%0d want dout=%0d rem=%0d",
                     $signed(dout), $signed(rem), $signed(e.dout), $signed(e.rem));
        end
    endtask

    task automatic test_ce_stall();
        int   edges;
        res_t e;
        sb.push_back(model(-8000, 13));
        start = 1'b1;
        din0 = 24'hFFE0C0;  // -8000
        din1 = 8'd13;
        @(posedge ap_clk);
        @(negedge ap_clk);
        start = 1'b0;
        edges = 0;
        while (edges < 200) begin
            @(posedge ap_clk);
            edges++;
            @(negedge ap_clk);
            ce = !(edges >= 5 && edges < 15);
            if (done) break;
        end
        ce = 1'b1;
        e = sb.pop_front();
        n_tests++;
        if (edges != 35 || !done) begin
            n_fail++;
            $display("FAIL ce_latency: got %0d want 35", edges);
        end
        n_tests++;
        if (dout !== e.dout || rem !== e.rem) begin
            n_fail++;
            $display("FAIL ce_result: got dout=%0d rem=%0d want dout=%0d rem=%0d",
                     $signed(dout), $signed(rem), $signed(e.dout), $signed(e.rem));
        end
        ce = 1'b0;
        repeat (3) @(negedge ap_clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ce_done_hold: got %b want 1", done);
        end
        ce = 1'b1;
        @(negedge ap_clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL ce_done_drop: got %b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        int extra;
        start = 1'b1;
        din0 = 24'd5000;
        din1 = 8'd9;
        @(posedge ap_clk);
        @(negedge ap_clk);
        start = 1'b0;
        repeat (11) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        n_tests++;
        if ({busy, done, dout, rem, ovf, div0} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b dout=%h rem=%h ovf=%b div0=%b want all 0",
                     busy, done, dout, rem, ovf, div0);
        end
        extra = 0;
        repeat (40) begin
            @(negedge ap_clk);
            if (done) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: got %0d dones want 0", extra);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_start_ignored();
        test_back_to_back();
        test_ce_stall();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
